// File: rtl/sqdist_mac_if.sv
// Element/result handshake bundle for sqdist_mac.
// The master side feeds element pairs and consumes results; the slave side is the MAC.
interface sqdist_mac_if #(
   parameter int Bit  = 8,
   parameter int AccW = 2*Bit+2+$clog2(17)
);
   logic                   clr;
   logic                   mode;
   logic                   in_valid;
   logic                   in_ready;
   logic signed [Bit-1:0]  inp_a;
   logic signed [Bit-1:0]  inp_b;
   logic                   res_valid;
   logic                   res_ready;
   logic signed [AccW-1:0] res;
   logic                   res_mode;

   modport master (
      output clr, mode, in_valid, inp_a, inp_b, res_ready,
      input  in_ready, res_valid, res, res_mode
   );

   modport slave (
      input  clr, mode, in_valid, inp_a, inp_b, res_ready,
      output in_ready, res_valid, res, res_mode
   );
endinterface

// File: rtl/sqdist_mac.sv
// Streaming squared-distance / dot-product accumulator.
// Three pipeline stages (difference, square/product, accumulate) feed a held
// result register. The whole pipe stalls while an unconsumed result is held.
module sqdist_mac #(
   parameter int Bit  = 8,
   parameter int Dim  = 16,
   parameter int AccW = 2*Bit+2+$clog2(Dim+1)
) (
   input logic        clk,
   input logic        rst,
   sqdist_mac_if.slave s
);
   localparam int CntW = (Dim > 1) ? $clog2(Dim) : 1;
   localparam int DW   = Bit + 1;
   localparam int PW   = 2*Bit + 2;
   localparam logic [CntW-1:0] CntLast = CntW'(Dim - 1);

   logic                   en;
   logic                   accept;
   logic                   rdy_q;
   logic [CntW-1:0]        cnt;
   logic                   first;
   logic                   last;
   logic                   mode_q;
   logic                   mode_cur;

   logic                   s1_v, s1_first, s1_last, s1_mode;
   logic signed [DW-1:0]   s1_x, s1_y;
   logic                   s2_v, s2_first, s2_last, s2_mode;
   logic signed [PW-1:0]   s2_p;
   logic                   s3_v, s3_last, s3_mode;
   logic signed [AccW-1:0] acc;

   logic signed [PW-1:0]   x_ext, y_ext, prod;
   logic signed [AccW-1:0] acc_in;

   logic                   res_valid_q, res_mode_q;
   logic signed [AccW-1:0] res_q;

   // The pipe only moves when the result slot is free or being drained.
   assign en         = !(res_valid_q && !s.res_ready);
   assign s.in_ready = rdy_q && en && !s.clr;
   assign accept     = s.in_valid && s.in_ready;
   assign first      = (cnt == '0);
   assign last       = (cnt == CntLast);
   // Mode is sampled on the first element and frozen for the rest of the vector.
   assign mode_cur   = first ? s.mode : mode_q;

   assign s.res_valid = res_valid_q;
   assign s.res       = res_q;
   assign s.res_mode  = res_mode_q;

   // Square of the difference, or signed product, at full width.
   always_comb begin
      x_ext  = PW'(s1_x);
      y_ext  = PW'(s1_y);
      prod   = s1_mode ? (x_ext * y_ext) : (x_ext * x_ext);
      acc_in = AccW'(s2_p);
   end

   // Ready comes up one edge after reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdy_q <= 1'b0;
      else      rdy_q <= 1'b1;
   end

   // Element counter and per-vector mode latch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         mode_q <= 1'b0;
      end else if (s.clr) begin
         cnt    <= '0;
      end else if (accept) begin
         cnt <= last ? '0 : cnt + CntW'(1);
         if (first) mode_q <= s.mode;
      end
   end

   // Stage 1: difference (mode 0) or raw operands (mode 1).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0; s1_mode <= 1'b0;
         s1_x <= '0;   s1_y <= '0;
      end else if (s.clr) begin
         s1_v <= 1'b0;
      end else if (en) begin
         s1_v     <= accept;
         s1_first <= first;
         s1_last  <= last;
         s1_mode  <= mode_cur;
         s1_x     <= mode_cur ? DW'(s.inp_a) : (DW'(s.inp_a) - DW'(s.inp_b));
         s1_y     <= DW'(s.inp_b);
      end
   end

   // Stage 2: square or product.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_v <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0; s2_mode <= 1'b0;
         s2_p <= '0;
      end else if (s.clr) begin
         s2_v <= 1'b0;
      end else if (en) begin
         s2_v     <= s1_v;
         s2_first <= s1_first;
         s2_last  <= s1_last;
         s2_mode  <= s1_mode;
         s2_p     <= prod;
      end
   end

   // Stage 3: accumulate; the first element of a vector overwrites the sum.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s3_v <= 1'b0; s3_last <= 1'b0; s3_mode <= 1'b0;
         acc  <= '0;
      end else if (s.clr) begin
         s3_v <= 1'b0;
         acc  <= '0;
      end else if (en) begin
         s3_v    <= s2_v;
         s3_last <= s2_last;
         s3_mode <= s2_mode;
         if (s2_v) acc <= s2_first ? acc_in : (acc + acc_in);
      end
   end

   // Result slot: loads on the last element, drains on res_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid_q <= 1'b0;
         res_mode_q  <= 1'b0;
         res_q       <= '0;
      end else if (s.clr) begin
         res_valid_q <= 1'b0;
      end else if (en) begin
         if (s3_v && s3_last) begin
            res_valid_q <= 1'b1;
            res_q       <= acc;
            res_mode_q  <= s3_mode;
         end else if (res_valid_q && s.res_ready) begin
            res_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sqdist_mac.sv
// Directed bench for sqdist_mac: a Dim=4 instance for vector tests and a
// Dim=1 instance for streaming and clr behaviour.
module tb_sqdist_mac;
   localparam int Bit   = 8;
   localparam int AccW4 = 2*Bit+2+$clog2(5);
   localparam int AccW1 = 2*Bit+2+$clog2(2);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sqdist_mac_if #(.Bit(Bit), .AccW(AccW4)) i4 ();
   sqdist_mac_if #(.Bit(Bit), .AccW(AccW1)) i1 ();

   sqdist_mac #(.Bit(Bit), .Dim(4)) u4 (.clk(clk), .rst(rst), .s(i4));
   sqdist_mac #(.Bit(Bit), .Dim(1)) u1 (.clk(clk), .rst(rst), .s(i1));

   int   cyc = 0;
   int   acc_cyc = 0;
   int   errors = 0;
   int   checks = 0;
   logic acc4 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) acc4 <= i4.in_valid && i4.in_ready;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one element to the Dim=4 instance and hold it until accepted.
   task automatic send(input int a, input int b, input logic m);
      int n;
      i4.inp_a    = 8'(a);
      i4.inp_b    = 8'(b);
      i4.mode     = m;
      i4.in_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!acc4 && n < 200);
      check("accept", acc4, 1);
      acc_cyc     = cyc;
      i4.in_valid = 1'b0;
   endtask

   task automatic wait_res(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!i4.res_valid && n < 50);
      check({tag, "_valid"}, i4.res_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      i4.clr = 0; i4.mode = 0; i4.in_valid = 0; i4.inp_a = 0; i4.inp_b = 0; i4.res_ready = 1;
      i1.clr = 0; i1.mode = 0; i1.in_valid = 0; i1.inp_a = 0; i1.inp_b = 0; i1.res_ready = 1;

      // Reset state, held across clock edges
      #12;
      check("rst_res_valid", i4.res_valid, 0);
      check("rst_res", i4.res, 0);
      check("rst_in_ready", i4.in_ready, 0);
      @(negedge clk); rst = 1'b1; #1;
      check("rel_in_ready_pre", i4.in_ready, 0);
      @(posedge clk); #1;
      check("rel_in_ready_post", i4.in_ready, 1);

      // Squared distance, extreme operands
      send(3, 1, 0); send(-2, 2, 0); send(127, -128, 0); send(-128, 127, 0);
      wait_res("v1");
      check("v1_res", i4.res, 130070);
      check("v1_mode", i4.res_mode, 0);
      check("v1_lat", cyc - acc_cyc, 3);
      @(negedge clk);
      check("v1_pop", i4.res_valid, 0);

      // Dot product with signed extremes
      send(-128, -128, 1); send(-128, 127, 1); send(5, -3, 1); send(0, 9, 1);
      wait_res("v2");
      check("v2_res", i4.res, 113);
      check("v2_mode", i4.res_mode, 1);
      check("v2_lat", cyc - acc_cyc, 3);

      // Mode changes mid-vector are ignored
      send(1, 0, 0); send(2, 0, 1); send(3, 0, 1); send(4, 0, 1);
      wait_res("v3");
      check("v3_res", i4.res, 30);
      check("v3_mode", i4.res_mode, 0);
      send(1, 1, 1); send(2, 1, 0); send(3, 1, 0); send(4, 1, 0);
      wait_res("v4");
      check("v4_res", i4.res, 10);
      check("v4_mode", i4.res_mode, 1);

      // Back-to-back vectors under result backpressure
      @(negedge clk);
      i4.res_ready = 1'b0;
      fork
         begin
            send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
            send(2, 1, 1); send(3, 1, 1); send(4, 1, 1); send(5, 1, 1);
         end
         begin
            wait_res("bp_a");
            check("bp_a_res", i4.res, 4);
            check("bp_a_mode", i4.res_mode, 0);
            check("bp_stall_ready", i4.in_ready, 0);
            repeat (3) @(negedge clk);
            check("bp_hold_res", i4.res, 4);
            check("bp_hold_valid", i4.res_valid, 1);
            check("bp_hold_ready", i4.in_ready, 0);
            i4.res_ready = 1'b1;
            @(posedge clk); #1;
            i4.res_ready = 1'b0;
            wait_res("bp_b");
            check("bp_b_res", i4.res, 14);
            check("bp_b_mode", i4.res_mode, 1);
            check("bp_b_lat", cyc - acc_cyc, 3);
         end
      join
      i4.res_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("bp_drain", i4.res_valid, 0);

      // Asynchronous reset in the middle of a vector
      send(100, 0, 0); send(100, 0, 0);
      @(negedge clk); #2;
      rst = 1'b0; #1;
      check("arst_res", i4.res, 0);
      check("arst_valid", i4.res_valid, 0);
      check("arst_in_ready", i4.in_ready, 0);
      @(negedge clk);
      rst = 1'b1;
      send(10, 0, 0); send(0, 0, 0); send(0, 0, 0); send(0, 5, 0);
      wait_res("v5");
      check("v5_res", i4.res, 125);
      check("v5_lat", cyc - acc_cyc, 3);

      // Dim=1 streaming, clr drops in-flight results
      for (int j = 1; j <= 13; j++) begin
         @(negedge clk);
         if (j >= 2 && j <= 4) check($sformatf("d1_idle_%0d", j), i1.res_valid, 0);
         if (j >= 5 && j <= 8) begin
            check($sformatf("d1_valid_%0d", j), i1.res_valid, 1);
            check($sformatf("d1_res_%0d", j), i1.res, (j - 4) * (j - 4));
         end
         if (j >= 9 && j <= 12) check($sformatf("d1_clr_%0d", j), i1.res_valid, 0);
         if (j == 13) begin
            check("d1_after_clr_valid", i1.res_valid, 1);
            check("d1_after_clr_res", i1.res, 81);
         end
         i1.clr      = (j == 8);
         i1.in_valid = (j <= 9);
         i1.inp_a    = 8'(j);
         i1.inp_b    = 8'(0);
      end
      i1.in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sqdist_mac.md
SQDIST_MAC -- requirements
Module: sqdist_mac

Interface
REQ-001 SHALL have parameter Bit, default 8: signed width of each input operand.
REQ-002 SHALL have parameter Dim, default 16: number of elements per vector (>=1).
REQ-003 SHALL have parameter AccW, default 2*Bit+2+$clog2(Dim+1): signed result width.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low (asserted at 0).
REQ-006 SHALL have port clr, input, 1: synchronous flush of the pipeline, counter and result.
REQ-007 SHALL have port mode, input, 1: 0 = squared difference (a-b)^2, 1 = product a*b (dot product).
REQ-008 SHALL have port in_valid, input, 1: element pair is valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts an element this cycle.
REQ-010 SHALL have port inp_a, input, Bit, signed: operand A element.
REQ-011 SHALL have port inp_b, input, Bit, signed: operand B element.
REQ-012 SHALL have port res_valid, output, 1: completed vector result is held.
REQ-013 SHALL have port res_ready, input, 1: consumer takes the result.
REQ-014 SHALL have port res, output, AccW, signed: accumulated sum over Dim elements.
REQ-015 SHALL have port res_mode, output, 1: mode that res was computed in.

Function
REQ-016 SHALL accept an element when in_valid && in_ready at a rising edge.
REQ-017 SHALL drive in_ready = !(res_valid && !res_ready) && !clr; no combinational path from in_valid to in_ready.
REQ-018 SHALL advance all three pipeline stages only when en = !(res_valid && !res_ready); when en is 0, all stages hold.
REQ-019 Stage 1 SHALL register d = inp_a - inp_b (Bit+1 bits, sign-extended) in mode 0, or inp_a and inp_b in mode 1.
REQ-020 Stage 2 SHALL register d*d (unsigned, 2*Bit+1 bits, max 2^(2*Bit)) in mode 0, or the signed product inp_a*inp_b (2*Bit bits) in mode 1.
REQ-021 Stage 3 SHALL add the sign-correct extension of the stage-2 value to the accumulator. The first element of a vector SHALL load the accumulator instead of adding to it.
REQ-022 SHALL count accepted elements 0..Dim-1 and wrap to 0 after the Dim-th element; the last-element flag travels with the data through the stages.
REQ-023 SHALL latch mode on the first element of each vector (count 0); mode changes mid-vector SHALL be ignored until the next vector.
REQ-024 When the last element leaves stage 3, SHALL load res, load res_mode and set res_valid exactly 3 en-cycles after that element was accepted.
REQ-025 SHALL keep res, res_mode and res_valid stable while res_valid && !res_ready.
REQ-026 SHALL clear res_valid on the edge where res_valid && res_ready, unless a new result loads on the same edge; then res_valid stays 1 with the new value.
REQ-027 SHALL sustain one element per cycle and back-to-back vectors with no bubble when res_ready is held at 1.
REQ-028 SHALL never overflow: AccW covers Dim*2^(2*Bit) in mode 0 and Dim*2^(2*Bit-2) in mode 1.
REQ-029 For Dim=1, SHALL treat every element as both first and last.
REQ-030 clr SHALL take priority over acceptance, zero the counter, stage-valid bits, accumulator and res_valid, and discard any partial vector.

Reset
REQ-031 While rst=0, SHALL force res=0, res_mode=0, res_valid=0, count=0, all stage-valid bits 0 and the accumulator to 0, independent of clk.
REQ-032 SHALL drive in_ready=0 while rst=0, and in_ready=1 from the first edge after release if res_ready is not blocking.
REQ-033 Reset mid-vector SHALL discard the partial vector; the next accepted element is count 0.

Verification
REQ-034 Bit=8, Dim=4, mode 0, a={3,-2,127,-128}, b={1,2,-128,127}, res_ready=1 -> res=4+16+65025+65025=130070, res_valid for 1 cycle, 3 cycles after the last accept.
REQ-035 Mode 1, a={-128,-128,5,0}, b={-128,127,-3,9} -> res=16384-16256-15=113, res_mode=1.
REQ-036 Two back-to-back vectors with res_ready=0 -> after the first result, in_ready=0 and the pipeline freezes; res_ready pulsed 1 -> the first result pops, the second arrives 3 cycles later, and no element is lost or duplicated.
REQ-037 mode toggled after element 1 of a vector -> that vector completes in the original mode; the next vector uses the new mode.
REQ-038 rst=0 asserted asynchronously after 2 of 4 elements -> outputs 0 immediately; a fresh 4-element vector after release gives the correct result.
REQ-039 Dim=1, continuous elements a=i, b=0 -> res=i^2 every cycle; clr mid-stream -> res_valid=0 the next cycle and the in-flight results are dropped.
